// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake, skid buffer and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall/perf_flush counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IMM_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        beq,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        redirect
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, stale_q, stale_d;
   logic [31:0] id_instr_q, id_instr_d, id_pc4_q, id_pc4_d;
   logic [31:0] skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] pc4, br_tgt, j_tgt, tgt;
   assign pc4       = pc_q + 32'd4;
   assign br_tgt    = id_pc4_q + ({{16{id_instr_q[15]}}, id_instr_q[15:0]} << IMM_SHIFT);
   assign j_tgt     = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
   assign tgt       = jump ? j_tgt : br_tgt;
   assign redirect  = id_valid_q & ~stall & ((beq & zero) | (bne & ~zero) | jump);
   assign imem_req  = (state_q == FETCH) | (state_q == DISCARD);
   assign imem_addr = (state_q == DISCARD) ? stale_q : pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc4    = id_pc4_q;
   assign opcode    = id_instr_q[31:26];
   assign funct     = id_instr_q[5:0];
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stale_d      = stale_q;
      id_instr_d   = id_instr_q;
      id_pc4_d     = id_pc4_q;
      id_valid_d   = id_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (redirect) begin
               pc_d       = tgt;
               id_valid_d = 1'b0;
               // the in-flight request must still be retired at its old address
               if (!imem_ready) begin
                  stale_d = pc_q;
                  state_d = DISCARD;
               end
            end else if (imem_ready && !stall) begin
               id_instr_d = imem_rdata;
               id_pc4_d   = pc4;
               id_valid_d = 1'b1;
               pc_d       = pc4;
            end else if (imem_ready) begin
               skid_instr_d = imem_rdata;
               skid_pc4_d   = pc4;
               pc_d         = pc4;
               state_d      = HOLD;
            end else if (!stall) begin
               id_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d       = tgt;
               id_valid_d = 1'b0;
               state_d    = FETCH;
            end else if (!stall) begin
               id_instr_d = skid_instr_q;
               id_pc4_d   = skid_pc4_q;
               id_valid_d = 1'b1;
               state_d    = FETCH;
            end
         end
         DISCARD: begin
            id_valid_d = 1'b0;
            if (imem_ready) state_d = FETCH;
         end
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         stale_q      <= '0;
         id_instr_q   <= '0;
         id_pc4_q     <= '0;
         id_valid_q   <= 1'b0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_q      <= stale_d;
         id_instr_q   <= id_instr_d;
         id_pc4_q     <= id_pc4_d;
         id_valid_q   <= id_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;
   logic        fetched_inc;
   assign fetched_inc  = ~redirect & ~stall & (((state_q == FETCH) & imem_ready) | (state_q == HOLD));
   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
   assign perf_flush   = perf_flush_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_q + {31'd0, fetched_inc};
         perf_stall_q   <= perf_stall_q + {31'd0, stall};
         perf_flush_q   <= perf_flush_q + {31'd0, redirect};
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with default, wrapping and high reset PCs.
module tb_fetch_stage;
   logic        clk, rst_n, stall, beq, bne, jump, zero, ready;
   logic        a_req, a_valid, a_redir, w_req, w_valid, w_redir, j_req, j_valid, j_redir;
   logic [31:0] a_addr, a_instr, a_pc4, a_rdata;
   logic [31:0] w_addr, w_instr, w_pc4, w_rdata;
   logic [31:0] j_addr, j_instr, j_pc4, j_rdata;
   logic [5:0]  a_op, a_fn, w_op, w_fn, j_op, j_fn;
   int          passed = 0;
   int          total  = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h0000_001C) ? 32'h1000_FFFE :
             (a == 32'h1000_000C) ? 32'h0800_0040 : {8'h40, a[23:0]};
   endfunction

   assign a_rdata = ready ? mem(a_addr) : 32'hDEAD_BEEF;
   assign w_rdata = ready ? mem(w_addr) : 32'hDEAD_BEEF;
   assign j_rdata = ready ? mem(j_addr) : 32'hDEAD_BEEF;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
      .imem_req(a_req), .imem_addr(a_addr), .imem_ready(ready), .imem_rdata(a_rdata),
      .id_valid(a_valid), .id_instr(a_instr), .id_pc4(a_pc4), .opcode(a_op), .funct(a_fn),
      .redirect(a_redir)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst_n(rst_n), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(ready), .imem_rdata(w_rdata),
      .id_valid(w_valid), .id_instr(w_instr), .id_pc4(w_pc4), .opcode(w_op), .funct(w_fn),
      .redirect(w_redir)
   );

   fetch_stage #(.RESET_PC(32'h1000_0008)) dut_j (
      .clk(clk), .rst_n(rst_n), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
      .imem_req(j_req), .imem_addr(j_addr), .imem_ready(ready), .imem_rdata(j_rdata),
      .id_valid(j_valid), .id_instr(j_instr), .id_pc4(j_pc4), .opcode(j_op), .funct(j_fn),
      .redirect(j_redir)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 0; rst_n = 0; stall = 0; beq = 0; bne = 0; jump = 0; zero = 0; ready = 1;
      #2;
      chk("rst_req", a_req, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_instr", a_instr, 0);
      chk("rst_pc4", a_pc4, 0);
      chk("rst_opcode", a_op, 0);
      chk("rst_funct", a_fn, 0);
      chk("rst_redirect", a_redir, 0);
      tick(); rst_n = 1; #1;
      chk("boot_req", a_req, 0);
      tick();
      chk("f0_req", a_req, 1);
      chk("f0_addr", a_addr, 32'h0);
      tick();
      chk("f1_instr", a_instr, 32'h4000_0000);
      chk("f1_pc4", a_pc4, 32'h4);
      chk("f1_addr", a_addr, 32'h4);
      tick();
      chk("f2_instr", a_instr, 32'h4000_0004);
      chk("f2_pc4", a_pc4, 32'h8);
      chk("f2_addr", a_addr, 32'h8);
      stall = 1;
      repeat (3) begin
         tick();
         chk("hold_req", a_req, 0);
         chk("hold_instr", a_instr, 32'h4000_0004);
      end
      stall = 0;
      tick();
      chk("unstall_instr", a_instr, 32'h4000_0008);
      chk("unstall_pc4", a_pc4, 32'hC);
      chk("unstall_addr", a_addr, 32'hC);
      chk("unstall_req", a_req, 1);
      tick();
      chk("after_skid_instr", a_instr, 32'h4000_000C);
      chk("after_skid_addr", a_addr, 32'h10);
      repeat (4) tick();
      chk("beq_instr", a_instr, 32'h1000_FFFE);
      chk("beq_pc4", a_pc4, 32'h20);
      chk("beq_opcode", a_op, 6'h04);
      chk("beq_funct", a_fn, 6'h3E);
      beq = 1; zero = 1; #1;
      chk("beq_redirect", a_redir, 1);
      tick(); beq = 0; zero = 0; #1;
      chk("beq_flush_valid", a_valid, 0);
      chk("beq_target_addr", a_addr, 32'h18);
      tick();
      chk("beq_tgt_instr", a_instr, 32'h4000_0018);
      chk("beq_tgt_valid", a_valid, 1);
      tick();
      chk("bne_instr", a_instr, 32'h1000_FFFE);
      bne = 1; zero = 1; #1;
      chk("bne_no_redirect", a_redir, 0);
      tick();
      chk("bne_seq_instr", a_instr, 32'h4000_0020);
      chk("bne_seq_pc4", a_pc4, 32'h24);
      chk("bne_seq_addr", a_addr, 32'h24);
      bne = 0; zero = 0; ready = 0; jump = 1; #1;
      chk("disc_redirect", a_redir, 1);
      tick(); jump = 0; #1;
      chk("disc_addr1", a_addr, 32'h24);
      chk("disc_req1", a_req, 1);
      chk("disc_valid1", a_valid, 0);
      tick();
      chk("disc_addr2", a_addr, 32'h24);
      chk("disc_valid2", a_valid, 0);
      ready = 1;
      tick();
      chk("disc_done_addr", a_addr, 32'h80);
      chk("disc_done_valid", a_valid, 0);
      tick();
      chk("disc_tgt_instr", a_instr, 32'h4000_0080);
      chk("disc_tgt_pc4", a_pc4, 32'h84);
      #1 rst_n = 0; #1;
      chk("midrst_req", a_req, 0);
      chk("midrst_valid", a_valid, 0);
      chk("midrst_instr", a_instr, 0);
      tick(); tick(); rst_n = 1;
      tick();
      chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      chk("jmp_addr0", j_addr, 32'h1000_0008);
      tick();
      chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
      chk("wrap_pc4_1", w_pc4, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr2", w_addr, 32'h0);
      chk("wrap_pc4_2", w_pc4, 32'h0);
      chk("jmp_instr", j_instr, 32'h0800_0040);
      chk("jmp_pc4", j_pc4, 32'h1000_0010);
      jump = 1; #1;
      chk("jmp_redirect", j_redir, 1);
      tick(); jump = 0; #1;
      chk("jmp_target", j_addr, 32'h1000_0100);
      chk("jmp_flush_valid", j_valid, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
